// File: rtl/uart_key_decoder.sv
// 8N1 UART receiver feeding a four-key paddle decoder. Each key output stays high
// for HOLD_CYCLES clocks after its last keypress, which smooths over terminal auto-repeat.
module uart_key_decoder #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int HOLD_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT + 1);
  localparam int NUM_KEYS     = 4;
  localparam int CW           = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;

  rx_state_e     state, state_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift, shift_d;
  logic          load_byte, err_pulse;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], uart_rx};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      bit_idx   <= bit_idx_d;
      shift     <= shift_d;
      rx_valid  <= load_byte;
      frame_err <= err_pulse;
      if (load_byte) rx_byte <= shift;
    end
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    load_byte = 1'b0;
    err_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        // Mid-start-bit recheck rejects short low glitches.
        if (timer == TW'(HALF_BIT - 1)) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      DATA: begin
        if (timer == TW'(CLKS_PER_BIT - 1)) begin
          timer_d   = '0;
          shift_d   = {rx_s, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      STOP: begin
        if (timer == TW'(CLKS_PER_BIT - 1)) begin
          timer_d   = '0;
          load_byte = rx_s;
          err_pulse = !rx_s;
          state_d   = rx_s ? IDLE : WAIT_HIGH;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      WAIT_HIGH: begin
        // A held-low break must not look like a stream of start bits.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Key lanes: 0 p1_up, 1 p1_down, 2 p2_up, 3 p2_down; lane i^1 is the opposing direction.
  logic [NUM_KEYS-1:0]         key_hit, key_clr, key_on;
  logic [NUM_KEYS-1:0][CW-1:0] hold_cnt;
  logic                        is_space;

  always_comb begin
    key_hit    = '0;
    key_hit[0] = rx_valid && ((rx_byte | 8'h20) == 8'h77);
    key_hit[1] = rx_valid && ((rx_byte | 8'h20) == 8'h73);
    key_hit[2] = rx_valid && ((rx_byte | 8'h20) == 8'h6F);
    key_hit[3] = rx_valid && ((rx_byte | 8'h20) == 8'h6C);
  end
  assign is_space = rx_valid && (rx_byte == 8'h20);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    localparam int OPP = i ^ 1;
    assign key_clr[i] = is_space | key_hit[OPP];
    assign key_on[i]  = (hold_cnt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_clr[i])              hold_cnt[i] <= '0;
        else if (key_hit[i])         hold_cnt[i] <= CW'(HOLD_CYCLES);
        else if (hold_cnt[i] != '0)  hold_cnt[i] <= hold_cnt[i] - CW'(1);
      end
    end
  end

  assign p1_up   = key_on[0];
  assign p1_down = key_on[1];
  assign p2_up   = key_on[2];
  assign p2_down = key_on[3];

endmodule

// File: tb/tb_uart_key_decoder.sv
// Self-checking bench for uart_key_decoder: directed scenarios plus random key traffic,
// with a per-cycle reference of the four hold outputs and a queue of expected frame events.
module tb_uart_key_decoder;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HOLD     = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err;

  always #5 clk = ~clk;

  uart_key_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  typedef struct {
    logic [7:0] b;
    bit         err;
    int         start;
  } exp_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    n_valid = 0;
  int    n_ferr = 0;
  int    hold_end [4] = '{0, 0, 0, 0};
  exp_t  evq [$];
  string nm [4] = '{"p1_up", "p1_down", "p2_up", "p2_down"};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: key k is high for the HOLD cycles following the rx_valid cycle that named it.
  function automatic int key_of(input logic [7:0] b);
    case (b)
      8'h77, 8'h57: return 0;
      8'h73, 8'h53: return 1;
      8'h6F, 8'h4F: return 2;
      8'h6C, 8'h4C: return 3;
      default:      return -1;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    int   lo;
    int   k;
    logic [3:0] outs;
    outs = {p2_down, p2_up, p1_down, p1_up};
    for (int i = 0; i < 4; i++)
      chk(nm[i], outs[i], (cyc <= hold_end[i]) ? 1 : 0);
    if (rx_valid === 1'b1 || frame_err === 1'b1) begin
      if (rx_valid === 1'b1)  n_valid++;
      if (frame_err === 1'b1) n_ferr++;
      if (evq.size() == 0) begin
        chk("spurious_event", {rx_valid, frame_err}, 2'b00);
      end else begin
        e = evq.pop_front();
        chk("event_kind", {rx_valid, frame_err}, e.err ? 2'b01 : 2'b10);
        lo = e.start + 9 * CPB + CPB / 2;
        chk("event_latency", (cyc >= lo && cyc <= lo + 4) ? 1 : 0, 1);
        if (!e.err) begin
          chk("rx_byte", rx_byte, e.b);
          k = key_of(e.b);
          if (e.b == 8'h20) begin
            for (int i = 0; i < 4; i++) hold_end[i] = cyc;
          end else if (k >= 0) begin
            hold_end[k]     = cyc + HOLD;
            hold_end[k ^ 1] = cyc;
          end
        end
      end
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) hold_end[i] = 0;
      evq.delete();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; abort_bit >= 0 pulses reset during that data bit and releases the line.
  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input int abort_bit);
    exp_t e;
    e.b = b; e.err = bad_stop; e.start = cyc;
    evq.push_back(e);
    uart_rx = 1'b0;
    idle(CPB);
    for (int k = 0; k < 8; k++) begin
      if (k == abort_bit) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        uart_rx = 1'b1;
        return;
      end
      uart_rx = b[k];
      idle(CPB);
    end
    uart_rx = !bad_stop;
    idle(CPB);
    if (bad_stop) idle(20 * CPB);
    uart_rx = 1'b1;
  endtask

  logic [7:0] key_tab [10] = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h6F, 8'h4F, 8'h6C, 8'h4C, 8'h20, 8'h00};

  initial begin : stim
    int v0, f0;
    logic [7:0] b;
    rst = 1'b1;
    uart_rx = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_outputs", {p2_down, p2_up, p1_down, p1_up}, 4'h0);
    idle(5);

    // single 'w': one pulse, p1_up held HOLD cycles (per-cycle model checks the window)
    v0 = n_valid;
    send_frame(8'h77, 1'b0, -1);
    idle(HOLD + 50);
    chk("w_valid_count", n_valid - v0, 1);
    chk("w_rx_byte", rx_byte, 8'h77);
    chk("w_p1_up_expired", p1_up, 0);

    // 'o' twice ~500 cycles apart keeps p2_up high continuously
    send_frame(8'h6F, 1'b0, -1);
    idle(340);
    send_frame(8'h6F, 1'b0, -1);
    idle(700);
    chk("o_repeat_held", p2_up, 1);
    idle(400);
    chk("o_repeat_expired", p2_up, 0);

    // 'W' then 'S' swaps direction; space clears everything
    send_frame(8'h57, 1'b0, -1);
    idle(20);
    send_frame(8'h53, 1'b0, -1);
    idle(5);
    chk("ws_p1_down", p1_down, 1);
    chk("ws_p1_up", p1_up, 0);
    send_frame(8'h20, 1'b0, -1);
    idle(5);
    chk("space_clear", {p2_down, p2_up, p1_down, p1_up}, 4'h0);

    // bad stop bit plus long break: one frame_err, no decode
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h6C, 1'b1, -1);
    idle(10);
    chk("break_ferr_count", n_ferr - f0, 1);
    chk("break_valid_count", n_valid - v0, 0);
    chk("break_p2_down", p2_down, 0);
    send_frame(8'h6C, 1'b0, -1);
    idle(5);
    chk("l_after_break", p2_down, 1);

    // short low glitch on idle line is ignored
    v0 = n_valid; f0 = n_ferr;
    uart_rx = 1'b0;
    idle(5);
    uart_rx = 1'b1;
    idle(3 * CPB);
    chk("glitch_valid", n_valid - v0, 0);
    chk("glitch_ferr", n_ferr - f0, 0);
    send_frame(8'h77, 1'b0, -1);
    idle(5);
    chk("glitch_then_w", rx_byte, 8'h77);

    // reset mid-frame while p2_up is held
    send_frame(8'h6F, 1'b0, -1);
    idle(10);
    v0 = n_valid;
    send_frame(8'h77, 1'b0, 2);
    idle(3);
    chk("midrst_outputs", {p2_down, p2_up, p1_down, p1_up}, 4'h0);
    chk("midrst_rx_byte", rx_byte, 8'h00);
    send_frame(8'h73, 1'b0, -1);
    idle(5);
    chk("midrst_valid_count", n_valid - v0, 1);
    chk("midrst_then_s", p1_down, 1);

    // random key traffic with varied spacing
    for (int n = 0; n < 25; n++) begin
      b = key_tab[$urandom_range(0, 9)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b0, -1);
      chk("rand_rx_byte", rx_byte, b);
      idle($urandom_range(1, 700));
    end

    idle(HOLD + 20);
    chk("events_drained", evq.size(), 0);
    chk("final_outputs", {p2_down, p2_up, p1_down, p1_up}, 4'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
